// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Responder side of the data-memory port. Doubleword-wide memory
//               behind valid/ready request and response handshakes with a
//               fixed, configurable access latency, byte write strobes and
//               an error flag for misaligned or out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_LAST  = 4'(LATENCY - 1);
    localparam logic [60:0] c_DEPTH = 61'(DEPTH_WORDS);

    // Reject latencies the 4-bit wait counter cannot represent.
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_count;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [7:0]    r_wstrb;
    logic [63:0]   r_mem [DEPTH_WORDS];

    logic          w_err;
    logic [c_AW-1:0] w_idx;

    // Address decode of the captured request.
    assign w_err = (r_addr[2:0] != 3'b000) || (r_addr[63:3] >= c_DEPTH);
    assign w_idx = r_addr[c_AW+2:3];

    // Request/response FSM; the memory access commits on the WAIT->RESP edge.
    // Every accepted request spends LATENCY edges in WAIT (one edge when
    // LATENCY is 1), so resp_valid always rises LATENCY edges after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            r_count    <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_write   <= req_write;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_count   <= '0;
                        req_ready <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_count == c_LAST) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        if (w_err || r_write) begin
                            resp_rdata <= '0;
                        end else begin
                            resp_rdata <= r_mem[w_idx];
                        end
                        if (r_write && !w_err) begin
                            for (int b = 0; b < 8; b++) begin
                                if (r_wstrb[b]) begin
                                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                                end
                            end
                        end
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                S_RESP: begin
                    // Outputs hold their values until the initiator takes them.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Three instances with
//               LATENCY 2, 3 and 1; a reference memory model feeds a
//               scoreboard queue that is checked at each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_write  [N];
    logic [63:0] req_addr   [N];
    logic [63:0] req_wdata  [N];
    logic [7:0]  req_wstrb  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [63:0] resp_rdata [N];
    logic        resp_err   [N];

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] mdl [N][64];
    time         last_acc [N];
    int          nvec = 0;
    int          nmis = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            dmem_responder #(
                .DEPTH_WORDS (64),
                .LATENCY     (g == 0 ? 2 : (g == 1 ? 3 : 1))
            ) u_dut (
                .clk        (clk),
                .reset      (reset),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_write  (req_write[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .req_wstrb  (req_wstrb[g]),
                .resp_valid (resp_valid[g]),
                .resp_ready (resp_ready[g]),
                .resp_rdata (resp_rdata[g]),
                .resp_err   (resp_err[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 64; i++)
                mdl[k][i] = '0;
    endtask

    task automatic model_req(input int k, input logic wr, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] strb,
                             output exp_t e);
        e.err   = (addr[2:0] != 3'b000) || (addr[63:3] >= 61'd64);
        e.rdata = '0;
        if (!e.err) begin
            if (wr) begin
                for (int b = 0; b < 8; b++)
                    if (strb[b]) mdl[k][addr[8:3]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = mdl[k][addr[8:3]];
            end
        end
    endtask

    // One full transaction on instance k. hold = cycles of response backpressure
    // (a stray request is presented during them); tie = resp_ready held at 1.
    task automatic do_req(input int k, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          input int hold, input bit tie,
                          output logic [63:0] rd, output logic er);
        exp_t e;
        exp_t got;
        int   m;
        @(negedge clk);
        if (!tie) resp_ready[k] = 1'b0;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_wstrb[k] = strb;
        model_req(k, wr, addr, wdata, strb, e);
        sb.push_back(e);
        m = 0;
        while (!req_ready[k] && m < 50) begin
            @(negedge clk);
            m++;
        end
        if (!req_ready[k]) check("req_ready_timeout", 64'(req_ready[k]), 64'd1);
        @(posedge clk);
        last_acc[k] = $time;
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = ~addr;
        req_wdata[k] = ~wdata;
        req_wstrb[k] = ~strb;
        m = 0;
        while (!resp_valid[k] && m < 40) begin
            @(negedge clk);
            m++;
        end
        check("latency", 64'(m), 64'(lat_of(k)));
        rd = resp_rdata[k];
        er = resp_err[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid[k] = 1'b1;
            req_write[k] = 1'b1;
            req_addr[k]  = 64'h10;
            req_wdata[k] = 64'h1111_1111_1111_1111;
            req_wstrb[k] = 8'hFF;
            check("hold_valid", 64'(resp_valid[k]), 64'd1);
            check("hold_rdata", resp_rdata[k], rd);
            check("hold_err", 64'(resp_err[k]), 64'(er));
            check("hold_req_ready", 64'(req_ready[k]), 64'd0);
        end
        req_valid[k] = 1'b0;
        if (!tie) resp_ready[k] = 1'b1;
        @(posedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            got.rdata = rd;
            got.err   = er;
            e = sb.pop_front();
            check("sb_rdata", got.rdata, e.rdata);
            check("sb_err", 64'(got.err), 64'(e.err));
        end
        if (!tie) begin
            @(negedge clk);
            resp_ready[k] = 1'b0;
            check("req_ready_after_hs", 64'(req_ready[k]), 64'd1);
            check("resp_valid_after_hs", 64'(resp_valid[k]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        time         prev;
        for (int k = 0; k < N; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            req_wstrb[k]  = '0;
            resp_ready[k] = 1'b0;
            last_acc[k]   = 0;
        end
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int k = 0; k < N; k++) begin
            check("rst_req_ready", 64'(req_ready[k]), 64'd1);
            check("rst_resp_valid", 64'(resp_valid[k]), 64'd0);
            check("rst_rdata", resp_rdata[k], 64'd0);
            check("rst_err", 64'(resp_err[k]), 64'd0);
        end

        // Full store then load
        do_req(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, rd, er);
        check("t1_store_rdata", rd, 64'd0);
        do_req(0, 1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t1_load", rd, 64'hDEADBEEF_CAFEF00D);
        check("t1_err", 64'(er), 64'd0);

        // Partial strobes and empty strobe
        do_req(0, 1'b1, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0, rd, er);
        do_req(0, 1'b1, 64'h18, 64'h0, 8'h0F, 0, 1'b0, rd, er);
        do_req(0, 1'b0, 64'h18, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t2_partial", rd, 64'hFFFFFFFF_00000000);
        do_req(0, 1'b1, 64'h18, 64'h1234_5678_9ABC_DEF0, 8'h00, 0, 1'b0, rd, er);
        check("t2_zero_strb_err", 64'(er), 64'd0);
        do_req(0, 1'b0, 64'h18, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t2_zero_strb_data", rd, 64'hFFFFFFFF_00000000);

        // Errors: misaligned and out of range
        do_req(0, 1'b1, 64'h08, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b0, rd, er);
        do_req(0, 1'b0, 64'h0C, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t3_misalign_err", 64'(er), 64'd1);
        check("t3_misalign_rdata", rd, 64'd0);
        do_req(0, 1'b0, 64'h200, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t3_range_err", 64'(er), 64'd1);
        check("t3_range_rdata", rd, 64'd0);
        do_req(0, 1'b1, 64'h0C, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 1'b0, rd, er);
        check("t3_store_err", 64'(er), 64'd1);
        do_req(0, 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t3_mem1_kept", rd, 64'h0123_4567_89AB_CDEF);

        // Backpressure with a stray request held during RESP
        do_req(0, 1'b0, 64'h10, 64'h0, 8'h00, 5, 1'b0, rd, er);
        check("t4_load", rd, 64'hDEADBEEF_CAFEF00D);
        do_req(0, 1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t4_no_stray_store", rd, 64'hDEADBEEF_CAFEF00D);

        // Reset one edge after accepting a store (LATENCY 3)
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 64'h20;
        req_wdata[1] = 64'hA5A5_A5A5_A5A5_A5A5;
        req_wstrb[1] = 8'hFF;
        check("t5_ready_before", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("t5_req_ready", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("t5_no_resp", 64'(resp_valid[1]), 64'd0);
            @(negedge clk);
        end
        do_req(1, 1'b0, 64'h20, 64'h0, 8'h00, 0, 1'b0, rd, er);
        check("t5_load_zero", rd, 64'd0);

        // LATENCY 1, resp_ready tied high, back-to-back
        resp_ready[2] = 1'b1;
        do_req(2, 1'b1, 64'h00, 64'h1111_2222_3333_4444, 8'hFF, 0, 1'b1, rd, er);
        prev = last_acc[2];
        do_req(2, 1'b1, 64'h08, 64'h5555_6666_7777_8888, 8'hFF, 0, 1'b1, rd, er);
        check("t6_period_st", 64'(last_acc[2] - prev), 64'd30);
        prev = last_acc[2];
        do_req(2, 1'b0, 64'h00, 64'h0, 8'h00, 0, 1'b1, rd, er);
        check("t6_period_ld0", 64'(last_acc[2] - prev), 64'd30);
        check("t6_ld0", rd, 64'h1111_2222_3333_4444);
        prev = last_acc[2];
        do_req(2, 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b1, rd, er);
        check("t6_period_ld1", 64'(last_acc[2] - prev), 64'd30);
        check("t6_ld1", rd, 64'h5555_6666_7777_8888);
        @(negedge clk);
        resp_ready[2] = 1'b0;

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
